// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: decodes a MIPS word into ALU op/A/B and write-back control.
// Optional stall-cycle counter is built when ID_EX_STALL_CNT_EN is defined.
module id_ex_stage #(
   parameter int WIDTH = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [31:0]      id_instr,
   input  logic [WIDTH-1:0] id_rs_data,
   input  logic [WIDTH-1:0] id_rt_data,
   input  logic             flush,
   input  logic             alu_stall,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic             ex_valid,
   output logic             ex_wreg,
   output logic [RADDR-1:0] ex_waddr,
   output logic [1:0]       ex_res_sel,
   output logic             ex_illegal,
   output logic [31:0]      stall_cycles
);

   localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                          OP_XOR = 4'h4, OP_NOR = 4'h5, OP_SLL = 4'h6, OP_SRL = 4'h7,
                          OP_SRA = 4'h8, OP_SLT = 4'h9, OP_MUL = 4'hA, OP_DIV = 4'hB;

   // id_valid/id_ready: a word transfers on a rising edge where both are high;
   // while id_ready is low the source holds its word and the EX slot is frozen.
   assign id_ready = ~alu_stall;

   logic [5:0]  opcode, funct;
   logic [4:0]  rt_f, rd_f, shamt;
   logic [15:0] imm;
   logic        unused_rs_field;

   assign opcode = id_instr[31:26];
   assign rt_f   = id_instr[20:16];
   assign rd_f   = id_instr[15:11];
   assign shamt  = id_instr[10:6];
   assign funct  = id_instr[5:0];
   assign imm    = id_instr[15:0];
   // Operands arrive already read from the register file, so the rs index itself is not needed.
   assign unused_rs_field = ^id_instr[25:21];

   logic [3:0]       d_op;
   logic [WIDTH-1:0] d_a, d_b;
   logic [RADDR-1:0] d_waddr;
   logic             d_wreg, d_illegal;
   logic [1:0]       d_res_sel;

   always_comb begin
      d_op      = OP_ADD;
      d_a       = '0;
      d_b       = '0;
      d_waddr   = '0;
      d_wreg    = 1'b0;
      d_res_sel = 2'd0;
      d_illegal = 1'b0;
      if (opcode == 6'h00) begin
         case (funct)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
            6'h04, 6'h06, 6'h07: begin
               case (funct)
                  6'h20, 6'h21: d_op = OP_ADD;
                  6'h22, 6'h23: d_op = OP_SUB;
                  6'h24:        d_op = OP_AND;
                  6'h25:        d_op = OP_OR;
                  6'h26:        d_op = OP_XOR;
                  6'h27:        d_op = OP_NOR;
                  6'h2A:        d_op = OP_SLT;
                  6'h04:        d_op = OP_SLL;
                  6'h06:        d_op = OP_SRL;
                  default:      d_op = OP_SRA;
               endcase
               d_a     = id_rs_data;
               d_b     = id_rt_data;
               d_waddr = RADDR'(rd_f);
               d_wreg  = 1'b1;
            end
            6'h00, 6'h02, 6'h03: begin
               d_op    = (funct == 6'h00) ? OP_SLL : (funct == 6'h02) ? OP_SRL : OP_SRA;
               d_a     = {{(WIDTH-5){1'b0}}, shamt};
               d_b     = id_rt_data;
               d_waddr = RADDR'(rd_f);
               d_wreg  = 1'b1;
            end
            6'h18, 6'h1A: begin
               d_op = (funct == 6'h18) ? OP_MUL : OP_DIV;
               d_a  = id_rs_data;
               d_b  = id_rt_data;
            end
            6'h10, 6'h12: begin
               d_waddr   = RADDR'(rd_f);
               d_wreg    = 1'b1;
               d_res_sel = (funct == 6'h10) ? 2'd1 : 2'd2;
            end
            default: d_illegal = 1'b1;
         endcase
      end else begin
         case (opcode)
            6'h08, 6'h09, 6'h0A: begin
               d_op = (opcode == 6'h0A) ? OP_SLT : OP_ADD;
               d_a  = id_rs_data;
               d_b  = {{(WIDTH-16){imm[15]}}, imm};
            end
            6'h0C, 6'h0D, 6'h0E: begin
               d_op = (opcode == 6'h0C) ? OP_AND : (opcode == 6'h0D) ? OP_OR : OP_XOR;
               d_a  = id_rs_data;
               d_b  = {{(WIDTH-16){1'b0}}, imm};
            end
            6'h0F: begin
               // LUI is a left shift of the immediate by 16.
               d_op = OP_SLL;
               d_a  = WIDTH'(16);
               d_b  = {{(WIDTH-16){1'b0}}, imm};
            end
            default: d_illegal = 1'b1;
         endcase
         if (!d_illegal) begin
            d_waddr = RADDR'(rt_f);
            d_wreg  = 1'b1;
         end
      end
      if (d_waddr == '0) d_wreg = 1'b0;
   end

   logic flush_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_op        <= '0;
         alu_A         <= '0;
         alu_B         <= '0;
         ex_valid      <= 1'b0;
         ex_wreg       <= 1'b0;
         ex_waddr      <= '0;
         ex_res_sel    <= '0;
         ex_illegal    <= 1'b0;
         flush_pending <= 1'b0;
      end else if (!alu_stall) begin
         flush_pending <= 1'b0;
         if (id_valid && !flush && !flush_pending) begin
            alu_op     <= d_op;
            alu_A      <= d_a;
            alu_B      <= d_b;
            ex_valid   <= 1'b1;
            ex_wreg    <= d_wreg;
            ex_waddr   <= d_waddr;
            ex_res_sel <= d_res_sel;
            ex_illegal <= d_illegal;
         end else begin
            alu_op     <= '0;
            alu_A      <= '0;
            alu_B      <= '0;
            ex_valid   <= 1'b0;
            ex_wreg    <= 1'b0;
            ex_waddr   <= '0;
            ex_res_sel <= '0;
            ex_illegal <= 1'b0;
         end
      end else if (flush) begin
         // The stalled MULT/DIV must keep its operands; the kill lands on the next capture.
         flush_pending <= 1'b1;
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt_q;
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_q <= '0;
      else if (alu_stall && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end
   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed test-plan steps followed by randomized traffic against a table-driven model.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic        id_ready;
   logic [31:0] id_instr = '0;
   logic [31:0] id_rs_data = '0;
   logic [31:0] id_rt_data = '0;
   logic        flush = 1'b0;
   logic        alu_stall = 1'b0;
   logic [3:0]  alu_op;
   logic [31:0] alu_A, alu_B;
   logic        ex_valid, ex_wreg, ex_illegal;
   logic [4:0]  ex_waddr;
   logic [1:0]  ex_res_sel;
   logic [31:0] stall_cycles;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .flush(flush), .alu_stall(alu_stall),
      .alu_op(alu_op), .alu_A(alu_A), .alu_B(alu_B), .ex_valid(ex_valid), .ex_wreg(ex_wreg),
      .ex_waddr(ex_waddr), .ex_res_sel(ex_res_sel), .ex_illegal(ex_illegal),
      .stall_cycles(stall_cycles)
   );

   // Reference tables: R-type funct -> op (reg/reg), const shifts, var shifts; I-type opcode -> op.
   int r_rr[int];
   int r_shc[int];
   int i_op[int];
   bit i_zext[int];

   // Model state: the expected EX slot
   int          m_op, m_res;
   logic [31:0] m_a, m_b, m_cnt;
   int          m_wa;
   bit          m_valid, m_wreg, m_ill, m_fp;

   task automatic model_bubble();
      m_op = 0; m_a = 0; m_b = 0; m_valid = 0; m_wreg = 0; m_wa = 0; m_res = 0; m_ill = 0;
   endtask

   task automatic ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      int opc, fn;
      opc = int'(ins[31:26]);
      fn  = int'(ins[5:0]);
      model_bubble();
      m_valid = 1;
      if (opc == 0) begin
         if (r_rr.exists(fn)) begin
            m_op = r_rr[fn]; m_a = rs; m_b = rt; m_wa = int'(ins[15:11]); m_wreg = 1;
         end else if (r_shc.exists(fn)) begin
            m_op = r_shc[fn]; m_a = 32'(ins[10:6]); m_b = rt; m_wa = int'(ins[15:11]); m_wreg = 1;
         end else if (fn == 'h18 || fn == 'h1A) begin
            m_op = (fn == 'h18) ? 10 : 11; m_a = rs; m_b = rt;
         end else if (fn == 'h10 || fn == 'h12) begin
            m_wa = int'(ins[15:11]); m_wreg = 1; m_res = (fn == 'h10) ? 1 : 2;
         end else
            m_ill = 1;
      end else if (i_op.exists(opc)) begin
         m_op = i_op[opc];
         m_a  = (opc == 'h0F) ? 32'd16 : rs;
         m_b  = i_zext[opc] ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
         m_wa = int'(ins[20:16]); m_wreg = 1;
      end else
         m_ill = 1;
      if (m_wa == 0) m_wreg = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_slot();
      check("alu_op", 32'(alu_op), 32'(m_op));
      check("ex_valid", 32'(ex_valid), 32'(m_valid));
      check("ex_wreg", 32'(ex_wreg), 32'(m_wreg));
      check("ex_res_sel", 32'(ex_res_sel), 32'(m_res));
      check("ex_illegal", 32'(ex_illegal), 32'(m_ill));
      check("stall_cycles", stall_cycles, m_cnt);
      if (m_wreg || !m_valid) check("ex_waddr", 32'(ex_waddr), 32'(m_wa));
      if (!m_ill) begin
         check("alu_A", alu_A, m_a);
         check("alu_B", alu_B, m_b);
      end
   endtask

   // One clock: drive at negedge, update the model at posedge, compare 1 ns later.
   task automatic step(input logic r, input logic v, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt, input logic fl, input logic st);
      @(negedge clk);
      rst = r; id_valid = v; id_instr = ins; id_rs_data = rs; id_rt_data = rt;
      flush = fl; alu_stall = st;
      #1 check("id_ready", 32'(id_ready), 32'(!st));
      @(posedge clk);
      if (r) begin
         model_bubble(); m_fp = 0;
      end else if (!st) begin
         if (v && !fl && !m_fp) ref_decode(ins, rs, rt);
         else model_bubble();
         m_fp = 0;
      end else if (fl)
         m_fp = 1;
`ifdef ID_EX_STALL_CNT_EN
      if (r) m_cnt = 0;
      else if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
      #1 check_slot();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] rf[20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00,
                             6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h18, 6'h1A, 6'h10, 6'h12, 6'h01};
      logic [5:0] io[8] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23};
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k < 5) begin
         w[31:26] = 6'h00;
         w[5:0] = rf[$urandom_range(0, 19)];
      end else if (k < 9)
         w[31:26] = io[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) begin
         w[20:16] = 5'd0;
         w[15:11] = 5'd0;
      end
      return w;
   endfunction

   localparam logic [31:0] I_ADDI = {6'h08, 5'd1, 5'd2, 16'hFFFD};
   localparam logic [31:0] I_SLL  = {6'h00, 5'd0, 5'd4, 5'd3, 5'd5, 6'h00};
   localparam logic [31:0] I_SRAV = {6'h00, 5'd2, 5'd3, 5'd5, 5'd0, 6'h07};
   localparam logic [31:0] I_MULT = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h18};
   localparam logic [31:0] I_DIV  = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h1A};
   localparam logic [31:0] I_ADD9 = {6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h20};
   localparam logic [31:0] I_MFLO = {6'h00, 5'd0, 5'd0, 5'd8, 5'd0, 6'h12};
   localparam logic [31:0] I_ADD0 = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20};
   localparam logic [31:0] I_BAD  = {6'h3F, 26'h0123456};

   initial begin
      r_rr = '{'h20: 0, 'h21: 0, 'h22: 1, 'h23: 1, 'h24: 2, 'h25: 3, 'h26: 4, 'h27: 5, 'h2A: 9,
               'h04: 6, 'h06: 7, 'h07: 8};
      r_shc = '{'h00: 6, 'h02: 7, 'h03: 8};
      i_op = '{'h08: 0, 'h09: 0, 'h0A: 9, 'h0C: 2, 'h0D: 3, 'h0E: 4, 'h0F: 6};
      i_zext = '{'h08: 0, 'h09: 0, 'h0A: 0, 'h0C: 1, 'h0D: 1, 'h0E: 1, 'h0F: 1};
      model_bubble(); m_fp = 0; m_cnt = 0;

      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, I_ADDI, 5, 6, 0, 0);

      step(0, 1, I_ADDI, 32'd10, 32'd99, 0, 0);
      check("addi_B", alu_B, 32'hFFFF_FFFD);
      check("addi_waddr", 32'(ex_waddr), 32'd2);
      step(0, 1, I_SLL, 32'd77, 32'd1, 0, 0);
      check("sll_A", alu_A, 32'd5);
      step(0, 1, I_SRAV, 32'd33, 32'h8000_0000, 0, 0);
      check("srav_op", 32'(alu_op), 32'd8);

      // MULT then 34 stalled cycles while decode keeps offering the next word
      step(0, 1, I_MULT, 32'd7, 32'hFFFF_FFFE, 0, 0);
      for (int i = 0; i < 34; i++) begin
         step(0, 1, I_ADD9, 32'd3, 32'd4, 0, 1);
         check("mult_hold_op", 32'(alu_op), 32'hA);
         check("mult_hold_B", alu_B, 32'hFFFF_FFFE);
      end
`ifdef ID_EX_STALL_CNT_EN
      check("stall_cnt_34", stall_cycles, 32'd34);
`endif
      step(0, 1, I_ADD9, 32'd3, 32'd4, 0, 0);
      check("after_stall_waddr", 32'(ex_waddr), 32'd9);

      // flush during a DIV stall kills the next capture only
      step(0, 1, I_DIV, 32'd100, 32'd7, 0, 0);
      step(0, 1, I_ADD9, 32'd1, 32'd2, 1, 1);
      step(0, 1, I_ADD9, 32'd1, 32'd2, 0, 1);
      check("div_hold_op", 32'(alu_op), 32'hB);
      step(0, 1, I_ADD9, 32'd1, 32'd2, 0, 0);
      check("flush_bubble", 32'(ex_valid), 32'd0);
      step(0, 1, I_ADD9, 32'd1, 32'd2, 0, 0);
      check("post_flush_valid", 32'(ex_valid), 32'd1);

      step(0, 1, I_MFLO, 32'd5, 32'd6, 0, 0);
      check("mflo_res_sel", 32'(ex_res_sel), 32'd2);
      step(0, 1, I_ADD0, 32'd5, 32'd6, 0, 0);
      check("add_r0_wreg", 32'(ex_wreg), 32'd0);
      step(0, 1, I_BAD, 32'd5, 32'd6, 0, 0);
      check("illegal_flag", 32'(ex_illegal), 32'd1);

      // reset in the middle of a MULT stall
      step(0, 1, I_MULT, 32'd9, 32'd9, 0, 0);
      step(0, 1, I_ADD9, 32'd1, 32'd1, 0, 1);
      step(0, 1, I_ADD9, 32'd1, 32'd1, 0, 1);
      step(1, 1, I_ADD9, 32'd1, 32'd1, 0, 1);
      step(0, 0, I_ADD9, 32'd1, 32'd1, 0, 0);
      check("rst_mid_stall_op", 32'(alu_op), 32'd0);

      for (int i = 0; i < 800; i++) begin
         logic r, v, fl, st;
         r  = ($urandom_range(0, 99) == 0);
         v  = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 3) == 0);
         step(r, v, rand_instr(), $urandom, $urandom, fl, st);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
